// File: rtl/ps2_keybuf_if.sv
// Bus between a PS/2 decoder/consumer and the key event buffer.
// The master drives decoded codes and pops events; the slave is the buffer.
interface ps2_keybuf_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [9:0]    code_in;
  logic          code_valid;
  logic          evt_rd;
  logic          ovf_clr;
  logic [12:0]   evt_data;
  logic          evt_valid;
  logic [CW-1:0] evt_count;
  logic          overflow;
  logic [2:0]    mod_state;

  modport master (
    output code_in, code_valid, evt_rd, ovf_clr,
    input  evt_data, evt_valid, evt_count, overflow, mod_state
  );

  modport slave (
    input  code_in, code_valid, evt_rd, ovf_clr,
    output evt_data, evt_valid, evt_count, overflow, mod_state
  );
endinterface

// File: rtl/ps2_keybuf.sv
// PS/2 key event buffer: tracks shift/ctrl/caps, suppresses typematic
// repeats, and queues {ext, brk, shift, ctrl, caps, scancode} events in a
// show-ahead FIFO with a sticky overflow flag.
module ps2_keybuf #(
  parameter int DEPTH         = 8,
  parameter int FILTER_REPEAT = 1
) (
  input logic          clk,
  input logic          rst,   // active-low, asynchronous assert
  ps2_keybuf_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Decoded fields of the incoming code
  logic       ext;
  logic       brk;
  logic [7:0] sc;

  // Modifier and filter state
  logic       lshift_q, lshift_d;
  logic       rshift_q, rshift_d;
  logic       lctrl_q,  lctrl_d;
  logic       rctrl_q,  rctrl_d;
  logic       caps_q,   caps_d;
  logic       held_q,   held_d;
  logic [8:0] last_make_q, last_make_d;

  // FIFO state
  logic [12:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          overflow_q, overflow_d;

  // Per-cycle control
  logic        suppress;
  logic        evt;
  logic        rd_en;
  logic        wr_en;
  logic        full;
  logic        ovf_evt;
  logic [12:0] entry;

  assign ext = bus.code_in[9];
  assign brk = bus.code_in[8];
  assign sc  = bus.code_in[7:0];

  // Next-state logic for filter, modifiers, FIFO pointers, count and overflow
  always_comb begin
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    lctrl_d     = lctrl_q;
    rctrl_d     = rctrl_q;
    caps_d      = caps_q;
    held_d      = held_q;
    last_make_d = last_make_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    // A make identical to the last make while still held is a typematic repeat
    suppress = (FILTER_REPEAT != 0) && bus.code_valid && !brk && held_q &&
               (last_make_q == {ext, sc});
    evt      = bus.code_valid && !suppress;

    if (bus.code_valid) begin
      if (!brk) begin
        if (!suppress) begin
          last_make_d = {ext, sc};
          held_d      = 1'b1;
        end
      end else if ({ext, sc} == last_make_q) begin
        held_d = 1'b0;
      end
    end

    if (evt) begin
      if (!ext && sc == 8'h12) lshift_d = !brk;
      if (!ext && sc == 8'h59) rshift_d = !brk;
      if (!ext && sc == 8'h14) lctrl_d  = !brk;
      if ( ext && sc == 8'h14) rctrl_d  = !brk;
      if (!ext && sc == 8'h58 && !brk) caps_d = !caps_q;
    end

    // Entry carries the modifier state after this code's own update
    entry = {ext, brk, lshift_d | rshift_d, lctrl_d | rctrl_d, caps_d, sc};

    full    = (count_q == FULL_COUNT);
    rd_en   = bus.evt_rd && (count_q != '0);
    wr_en   = evt && (!full || rd_en);
    ovf_evt = evt && full && !rd_en;

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en && !rd_en)      count_d = count_q + 1'b1;
    else if (rd_en && !wr_en) count_d = count_q - 1'b1;

    // A fresh overflow wins over a clear in the same cycle
    overflow_d = ovf_evt || (overflow_q && !bus.ovf_clr);
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      lctrl_q     <= 1'b0;
      rctrl_q     <= 1'b0;
      caps_q      <= 1'b0;
      held_q      <= 1'b0;
      last_make_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      lctrl_q     <= lctrl_d;
      rctrl_q     <= rctrl_d;
      caps_q      <= caps_d;
      held_q      <= held_d;
      last_make_q <= last_make_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // FIFO storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= entry;
  end

  assign bus.evt_data  = (count_q != '0) ? mem_q[rd_ptr_q] : 13'h0000;
  assign bus.evt_valid = (count_q != '0);
  assign bus.evt_count = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.mod_state = {lshift_q | rshift_q, lctrl_q | rctrl_q, caps_q};

endmodule
